// File: rtl/bin_bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Ports: clk/rst, start, auto_en, bin_in -> busy, done, valid, bcd_out, blank.
module bin_bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] last_val;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    corr;
  logic [BW-1:0]    scratch_n;
  logic [CW-1:0]    cnt;
  logic             trig;

  // Top-down zero scan; the units digit is never blanked.
  function automatic logic [DIGITS-1:0] blank_of(
    input logic [BW-1:0] v
  );
    logic z;
    z = 1'b1;
    blank_of = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (v[4*i +: 4] == 4'd0);
      blank_of[i] = z;
    end
  endfunction

  always_comb begin
    corr = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign scratch_n = {corr[BW-2:0], shreg[WIDTH-1]};

  // Start and an auto change in the same cycle merge into one trigger.
  assign trig = start | (auto_en & (bin_in != last_val));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      bcd_out  <= '0;
      blank    <= BLANK_RST;
      shreg    <= '0;
      last_val <= '0;
      scratch  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            shreg    <= bin_in;
            last_val <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_n;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            bcd_out <= scratch_n;
            blank   <= blank_of(scratch_n);
            done    <= 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
